xz_lane_framer: RTL
===================

Name: xz_lane_framer

Overview:
- Upstream feeder for the 45-bit 2-state frame consumer `bit [1:3][3:1][4:0]`.
- Accepts a stream of 5-bit 4-state lanes, such as the x/z-laden packed values the fssq-style sources produce.
- Sanitizes X/Z bits to a fixed 2-state fill value and packs LANES lanes into one frame.
- Emits each frame with a valid/ready handshake, plus a per-lane X/Z mask and a saturating X/Z lane counter.

Parameters:
- LANES, 9, lanes per frame; frame width is LANES*LANE_W.
- LANE_W, 5, bits per lane.
- XZ_FILL, 1'b0, 2-state value substituted for every X or Z input bit.
- CNT_W, 8, width of the saturating X/Z lane counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  lane offered.
- in_ready  output  1  lane accepted when in_valid && in_ready.
- in_lane  input  LANE_W  4-state lane data (logic).
- in_last  input  1  qualified with the lane handshake; closes a partial frame.
- out_valid  output  1  frame available.
- out_ready  input  1  frame consumed when out_valid && out_ready.
- out_frame  output  LANES*LANE_W  2-state (bit) packed frame.
- out_xz_mask  output  LANES  bit i set = lane i contained at least one X/Z bit.
- out_lanes  output  $clog2(LANES+1)  number of valid lanes in the frame (1..LANES).
- xz_count  output  CNT_W  saturating count of accepted lanes containing X/Z.
- clear_cnt  input  1  synchronous clear of xz_count.

Behaviour:
- Reset (async assert, sync release):
  - State = FILL, slot index = 0, frame/mask registers cleared.
  - out_valid=0, out_frame=0, out_xz_mask=0, out_lanes=0, xz_count=0, in_ready=1 after release.
- FSM has two states, FILL and HOLD.
  - FILL: in_ready=1, out_valid=0. On an accepted lane, the lane is written to slot idx and idx increments. The lane closes the frame if idx==LANES-1 or in_last=1; then next state = HOLD.
  - HOLD: in_ready=0, out_valid=1, outputs stable until out_ready. On out_ready: frame/mask/idx cleared, next state = FILL.
- Latency and throughput:
  - out_valid rises the cycle after the closing lane is accepted.
  - One bubble per frame (the HOLD cycle); this is accepted by design.
- Slot ordering:
  - The first lane of a frame lands in the most significant slot: out_frame[LANES*LANE_W-1 -: LANE_W], i.e. element [1][3] for the default shape.
  - Each subsequent lane lands in the next lower slot.
- Partial frames (in_last before LANES lanes): unfilled slots are 0, their mask bits are 0, and out_lanes = lanes received.
- Sanitizing: each in_lane bit that is X or Z is replaced by XZ_FILL; 0/1 bits pass unchanged. out_frame never carries X/Z.
- Mask: out_xz_mask[LANES-1-k] is set if the k-th accepted lane had any X/Z bit. The mask follows the same MSB-first slot order as the frame.
- xz_count:
  - Increments by 1 per accepted lane containing X/Z.
  - Saturates at 2^CNT_W-1; no wrap.
  - clear_cnt and an increment in the same cycle → count = 1 (clear, then count).
  - clear_cnt alone → 0.
- in_lane is ignored when in_valid=0 or in_ready=0. in_last is ignored without a handshake.
- Reset mid-frame: the partial frame is discarded, no out_valid is produced, and xz_count returns to 0.
- out_ready held high in FILL has no effect.

Test Plan:
- Full clean frame:
  - Stimulus: 9 lanes 5'b00001..5'b01001, out_ready=1.
  - Response: out_valid 1 cycle after the 9th lane; out_frame[44:40]=5'b00001 and [4:0]=5'b01001; out_xz_mask=0; out_lanes=9; xz_count=0.
- X/Z sanitizing (XZ_FILL=0):
  - Stimulus: lane0=5'bx00z1, lane1=5'bzzzzz, lanes 2..8 = 5'b11111.
  - Response: out_frame[44:40]=5'b00001, [39:35]=5'b00000; out_xz_mask=9'b110000000; xz_count=2.
- Partial frame plus backpressure:
  - Stimulus: 3 lanes with in_last on the 3rd, out_ready=0 for 4 cycles.
  - Response: out_lanes=3, slots 3..8 zero, outputs stable and in_ready=0 throughout the stall; after out_ready, in_ready=1 the next cycle.
- Counter saturation and clear (CNT_W=2):
  - Stimulus: 5 X-containing lanes.
  - Response: xz_count saturates at 3; clear_cnt together with an X lane gives 1; clear_cnt alone gives 0.
- Async reset mid-frame:
  - Stimulus: assert rst_n=0 between clock edges after 4 lanes.
  - Response: outputs clear immediately. A following 9-lane frame places its first lane in slot [44:40], with no residue from the discarded frame.
- Handshake gaps:
  - Stimulus: toggle in_valid randomly over 2 frames.
  - Response: lane order is preserved and no lane is dropped or duplicated (scoreboard match).

Source files
------------

// File: rtl/xz_lane_framer.sv
// Packs LANE_W-bit 4-state lanes MSB-slot-first into a 2-state frame, tagging X/Z lanes.
// out_valid rises one cycle after the closing lane; in_ready drops while a frame waits for out_ready.
module xz_lane_framer #(
    parameter int LANES   = 9,
    parameter int LANE_W  = 5,
    parameter bit XZ_FILL = 1'b0,
    parameter int CNT_W   = 8,
    localparam int FW     = LANES * LANE_W,
    localparam int IDX_W  = $clog2(LANES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_lane,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output bit   [FW-1:0]     out_frame,
    output logic [LANES-1:0]  out_xz_mask,
    output logic [IDX_W-1:0]  out_lanes,
    output logic [CNT_W-1:0]  xz_count,
    input  logic              clear_cnt
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    bit   [FW-1:0]      frame_q, frame_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_clean;
    logic               lane_xz;
    logic               accept;
    logic               close;

    // Unknown bits only exist in 4-state sources; real silicon always sees them as known.
    always_comb begin
        lane_clean = '0;
        lane_xz    = 1'b0;
        for (int b = 0; b < LANE_W; b++) begin
            if ($isunknown(in_lane[b])) begin
                lane_clean[b] = XZ_FILL;
                lane_xz       = 1'b1;
            end else begin
                lane_clean[b] = in_lane[b];
            end
        end
    end

    assign accept = in_valid && (state_q == FILL);
    assign close  = accept && (in_last || (idx_q == IDX_W'(LANES - 1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        mask_d  = mask_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    // Slot s counts up from the LSB, so lane idx lands in slot LANES-1-idx.
                    for (int s = 0; s < LANES; s++) begin
                        if (idx_q == IDX_W'(LANES - 1 - s)) begin
                            frame_d[s*LANE_W +: LANE_W] = lane_clean;
                            mask_d[s]                   = lane_xz;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    if (close) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    frame_d = '0;
                    mask_d  = '0;
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Clear takes effect first so a same-cycle X/Z lane still counts.
    always_comb begin
        cnt_d = clear_cnt ? '0 : cnt_q;
        if (accept && lane_xz && (cnt_d != {CNT_W{1'b1}})) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            frame_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == HOLD);
    assign out_frame   = frame_q;
    assign out_xz_mask = mask_q;
    assign out_lanes   = out_valid ? idx_q : '0;
    assign xz_count    = cnt_q;

endmodule
